// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, control-bit
// positions, ring states and the control words emitted in each T-state.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions inside CONTROL, MSB first: Cp Ep Lm_n Ce_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
  localparam int CP   = 11;
  localparam int EP   = 10;
  localparam int LM_N = 9;
  localparam int CE_N = 8;
  localparam int LI_N = 7;
  localparam int EI_N = 6;
  localparam int LA_N = 5;
  localparam int EA   = 4;
  localparam int SU   = 3;
  localparam int EU   = 2;
  localparam int LB_N = 1;
  localparam int LO_N = 0;

  localparam logic [11:0] NOP_W     = 12'h3E3;
  localparam logic [11:0] W_T1      = 12'h5E3;
  localparam logic [11:0] W_T2      = 12'hBE3;
  localparam logic [11:0] W_T3      = 12'h263;
  localparam logic [11:0] W_MEM_T4  = 12'h1A3;
  localparam logic [11:0] W_LDA_T5  = 12'h2C3;
  localparam logic [11:0] W_ALU_T5  = 12'h2E1;
  localparam logic [11:0] W_ADD_T6  = 12'h3C7;
  localparam logic [11:0] W_SUB_T6  = 12'h3CF;
  localparam logic [11:0] W_OUT_T4  = 12'h3F2;

  localparam logic [5:0] ST_T1 = 6'b000001;
  localparam logic [5:0] ST_T2 = 6'b000010;
  localparam logic [5:0] ST_T3 = 6'b000100;
  localparam logic [5:0] ST_T4 = 6'b001000;
  localparam logic [5:0] ST_T5 = 6'b010000;
  localparam logic [5:0] ST_T6 = 6'b100000;

  function automatic logic is_one_hot(input logic [5:0] s);
    return (s != 6'b0) && ((s & (s - 6'd1)) == 6'b0);
  endfunction

endpackage

// File: rtl/sap1_control_matrix_if.sv
// Bundle between the sequencer and the SAP-1 datapath.
// No handshake: CONTROL is valid for the whole T-state and the datapath
// registers consume it on the rising clock edge inside that state.
interface sap1_control_matrix_if;
  logic [3:0]  OPCODE;
  logic [11:0] CONTROL;
  logic [5:0]  T_STATE;
  logic        HLT;

  modport master (input OPCODE, output CONTROL, output T_STATE, output HLT);
  modport slave  (output OPCODE, input CONTROL, input T_STATE, input HLT);
endinterface

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring, advancing on the falling clock edge.
// A non-one-hot state (e.g. after an upset) is forced back to T1.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr_n,
  input  logic       hold,
  output logic [5:0] T_STATE
);

  logic [5:0] state;

  always_ff @(negedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= ST_T1;
    end else if (!is_one_hot(state)) begin
      state <= ST_T1;
    end else if (!hold) begin
      state <= {state[4:0], state[5]};
    end
  end

  assign T_STATE = state;

endmodule

// File: rtl/sap1_control_matrix.sv
// SAP-1 control sequencer: ring counter, halted flag and the combinational
// decode of (T-state, opcode, halted) into the 12-bit control word.
module sap1_control_matrix
  import sap1_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Clr_n,
  sap1_control_matrix_if.master  bus
);

  logic [5:0]  t_state;
  logic        halted;
  logic        hlt_decode;
  logic        hold;
  logic [11:0] control;

  // HLT shows up combinationally in T4; the flag keeps it asserted after the
  // opcode input is no longer trusted and keeps the ring frozen.
  assign hlt_decode = (t_state == ST_T4) && (bus.OPCODE == OP_HLT);
  assign hold       = halted | hlt_decode;

  always_ff @(negedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      halted <= 1'b0;
    end else if (hlt_decode) begin
      halted <= 1'b1;
    end
  end

  sap1_ring_counter u_ring (
    .Clk     (Clk),
    .Clr_n   (Clr_n),
    .hold    (hold),
    .T_STATE (t_state)
  );

  always_comb begin
    control = NOP_W;
    case (t_state)
      ST_T1: control = W_T1;
      ST_T2: control = W_T2;
      ST_T3: control = W_T3;
      ST_T4: begin
        if (!halted) begin
          case (bus.OPCODE)
            OP_LDA, OP_ADD, OP_SUB: control = W_MEM_T4;
            OP_OUT:                 control = W_OUT_T4;
            default:                control = NOP_W;
          endcase
        end
      end
      ST_T5: begin
        case (bus.OPCODE)
          OP_LDA:         control = W_LDA_T5;
          OP_ADD, OP_SUB: control = W_ALU_T5;
          default:        control = NOP_W;
        endcase
      end
      ST_T6: begin
        case (bus.OPCODE)
          OP_ADD:  control = W_ADD_T6;
          OP_SUB:  control = W_SUB_T6;
          default: control = NOP_W;
        endcase
      end
      default: control = NOP_W;
    endcase
  end

  assign bus.CONTROL = control;
  assign bus.T_STATE = t_state;
  assign bus.HLT     = hold;

endmodule

// File: tb/tb_sap1_control_matrix.sv
// Bench for sap1_control_matrix: opcode table walked through T1..T6 plus
// hand-written reset, halt and async-reset sequences.
module tb_sap1_control_matrix;

  logic Clk = 1'b0;
  logic Clr_n;

  always #5 Clk = ~Clk;

  sap1_control_matrix_if bus ();

  sap1_control_matrix dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  typedef struct {
    string            name;
    logic [3:0]       op;
    logic [5:0][11:0] w;
  } vec_t;

  vec_t        vecs[6];
  logic [18:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  function automatic vec_t mk(input string n, input logic [3:0] op,
                              input logic [11:0] w4, input logic [11:0] w5,
                              input logic [11:0] w6);
    vec_t v;
    v.name = n;
    v.op   = op;
    v.w    = {w6, w5, w4, 12'h263, 12'hBE3, 12'h5E3};
    return v;
  endfunction

  function automatic logic [18:0] pk(input int k, input logic h, input logic [11:0] c);
    logic [5:0] t;
    t = 6'b000001 << k;
    return {t, h, c};
  endfunction

  task automatic check(input string name);
    logic [18:0] e;
    logic [18:0] a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    a = {bus.T_STATE, bus.HLT, bus.CONTROL};
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got t_state=%b hlt=%b control=%h, expected t_state=%b hlt=%b control=%h",
               name, a[18:13], a[12], a[11:0], e[18:13], e[12], e[11:0]);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    #2;
  endtask

  task automatic run_instr(input vec_t v);
    for (int k = 0; k < 6; k++) exp_q.push_back(pk(k, 1'b0, v.w[k]));
    step();
    bus.OPCODE = v.op;
    check({v.name, "_t1"});
    for (int k = 1; k < 6; k++) begin
      step();
      check($sformatf("%s_t%0d", v.name, k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("lda",  4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    vecs[1] = mk("add",  4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    vecs[2] = mk("sub",  4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    vecs[3] = mk("out",  4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
    vecs[4] = mk("nop5", 4'h5, 12'h3E3, 12'h3E3, 12'h3E3);
    vecs[5] = mk("nop_rand", 4'($urandom_range(3, 13)), 12'h3E3, 12'h3E3, 12'h3E3);

    // Reset held with the clock running
    bus.OPCODE = 4'h5;
    Clr_n      = 1'b0;
    repeat (4) begin
      exp_q.push_back(pk(0, 1'b0, 12'h5E3));
      step();
      check("reset_hold");
    end

    // Release between edges; NOP instruction from T1 through T6
    Clr_n = 1'b1;
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    #1 check("release_t1");
    exp_q.push_back(pk(1, 1'b0, 12'hBE3));
    exp_q.push_back(pk(2, 1'b0, 12'h263));
    for (int k = 3; k < 6; k++) exp_q.push_back(pk(k, 1'b0, 12'h3E3));
    for (int k = 1; k < 6; k++) begin
      step();
      check($sformatf("release_t%0d", k + 1));
    end

    for (int i = 0; i < 6; i++) run_instr(vecs[i]);
    run_instr(vecs[0]);

    // HLT: freezes at T4 with HLT high and the inactive word
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    exp_q.push_back(pk(1, 1'b0, 12'hBE3));
    exp_q.push_back(pk(2, 1'b0, 12'h263));
    exp_q.push_back(pk(3, 1'b1, 12'h3E3));
    step();
    bus.OPCODE = 4'hF;
    check("hlt_t1");
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("hlt_t%0d", k + 1));
    end
    repeat (10) begin
      exp_q.push_back(pk(3, 1'b1, 12'h3E3));
      step();
      check("hlt_frozen");
    end
    bus.OPCODE = 4'h0;
    exp_q.push_back(pk(3, 1'b1, 12'h3E3));
    #1 check("hlt_opcode_change");

    Clr_n = 1'b0;
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    #1 check("hlt_clear");
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    step();
    check("hlt_clear_hold");
    Clr_n = 1'b1;
    for (int k = 1; k < 6; k++) exp_q.push_back(pk(k, 1'b0, vecs[0].w[k]));
    for (int k = 1; k < 6; k++) begin
      step();
      check($sformatf("after_hlt_t%0d", k + 1));
    end

    // Async reset in the middle of ADD T5
    for (int k = 0; k < 5; k++) exp_q.push_back(pk(k, 1'b0, vecs[1].w[k]));
    step();
    bus.OPCODE = 4'h1;
    check("mid_add_t1");
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("mid_add_t%0d", k + 1));
    end
    #1 Clr_n = 1'b0;
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    #1 check("async_reset_mid_t5");
    exp_q.push_back(pk(0, 1'b0, 12'h5E3));
    step();
    check("async_reset_hold");
    Clr_n = 1'b1;
    exp_q.push_back(pk(1, 1'b0, 12'hBE3));
    step();
    check("async_release_t2");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_queue: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
